// File: rtl/sr_puf_eval_ctrl.sv
// SR-latch PUF evaluation controller: excite, release, settle, sample.
// Majority-votes NUM_EVAL evaluations of one cell and returns the result.
//
// Ports:
//   clk_i, rst_n_i         clock, synchronous active-low reset
//   start_i, challenge_i   request + cell index (taken only in IDLE)
//   busy_o                 accept..response consumed
//   puf_a_o, puf_b_o       per-cell latch inputs (1 = hold)
//   puf_r_i                per-cell latch outputs (asynchronous)
//   resp_o, unstable_o     voted bit, non-unanimous flag
//   ones_cnt_o, err_o      evaluations that read 1, bad challenge
//   resp_valid_o/ready_i   response handshake
module sr_puf_eval_ctrl #(
  parameter int NUM_CELLS  = 8,
  parameter int SEL_W      = 3,
  parameter int EXCITE_CYC = 4,
  parameter int SETTLE_CYC = 16,
  parameter int NUM_EVAL   = 7
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic [SEL_W-1:0]     challenge_i,
  output logic                 busy_o,
  output logic [NUM_CELLS-1:0] puf_a_o,
  output logic [NUM_CELLS-1:0] puf_b_o,
  input  logic [NUM_CELLS-1:0] puf_r_i,
  output logic                 resp_o,
  output logic                 unstable_o,
  output logic [7:0]           ones_cnt_o,
  output logic                 err_o,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i
);

  localparam int CMAX  = (EXCITE_CYC > SETTLE_CYC) ?
                         EXCITE_CYC : SETTLE_CYC;
  localparam int CYC_W = $clog2(CMAX + 1);

  localparam logic [CYC_W-1:0] EX_LAST = CYC_W'(EXCITE_CYC - 1);
  localparam logic [CYC_W-1:0] ST_LAST = CYC_W'(SETTLE_CYC - 1);
  localparam logic [7:0]       EVALS   = 8'(NUM_EVAL);
  localparam logic [7:0]       HALF    = 8'(NUM_EVAL / 2);
  localparam logic [SEL_W:0]   NCELL   = (SEL_W + 1)'(NUM_CELLS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_EXCITE = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [CYC_W-1:0]     cyc_q, cyc_d;
  logic [7:0]           eval_q, eval_d;
  logic [7:0]           ones_q, ones_d;
  logic [NUM_CELLS-1:0] puf_q, puf_d;
  logic                 sync1_q, sync2_q;
  logic                 busy_q, busy_d;
  logic                 resp_q, resp_d;
  logic                 unst_q, unst_d;
  logic                 err_q, err_d;
  logic                 valid_q, valid_d;

  logic [NUM_CELLS-1:0] chal_oh;
  logic [NUM_CELLS-1:0] sel_oh;
  logic                 r_mux;
  logic                 bad_chal;

  // Out-of-range selects decode to no cell at all.
  always_comb begin
    chal_oh = '0;
    sel_oh  = '0;
    r_mux   = 1'b0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      chal_oh[i] = (challenge_i == SEL_W'(i));
      sel_oh[i]  = (sel_q == SEL_W'(i));
      if (sel_q == SEL_W'(i)) r_mux = puf_r_i[i];
    end
  end

  assign bad_chal = ({1'b0, challenge_i} >= NCELL);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cyc_d   = cyc_q;
    eval_d  = eval_q;
    ones_d  = ones_q;
    puf_d   = puf_q;
    busy_d  = busy_q;
    resp_d  = resp_q;
    unst_d  = unst_q;
    err_d   = err_q;
    valid_d = valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          sel_d  = challenge_i;
          cyc_d  = '0;
          eval_d = '0;
          ones_d = '0;
          busy_d = 1'b1;
          resp_d = 1'b0;
          unst_d = 1'b0;
          err_d  = bad_chal;
          if (bad_chal) begin
            state_d = S_DONE;
            valid_d = 1'b1;
          end else begin
            state_d = S_EXCITE;
            puf_d   = ~chal_oh;
          end
        end
      end
      S_EXCITE: begin
        if (cyc_q == EX_LAST) begin
          cyc_d   = '0;
          puf_d   = '1;
          state_d = S_SETTLE;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_SETTLE: begin
        if (cyc_q == ST_LAST) begin
          cyc_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        ones_d = ones_q + {7'd0, sync2_q};
        eval_d = eval_q + 8'd1;
        if (eval_d == EVALS) begin
          state_d = S_DONE;
          valid_d = 1'b1;
          resp_d  = (ones_d > HALF);
          unst_d  = (ones_d != 8'd0) && (ones_d != EVALS);
        end else begin
          state_d = S_EXCITE;
          puf_d   = ~sel_oh;
        end
      end
      S_DONE: begin
        if (resp_ready_i) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      cyc_q   <= '0;
      eval_q  <= '0;
      ones_q  <= '0;
      puf_q   <= '1;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      busy_q  <= 1'b0;
      resp_q  <= 1'b0;
      unst_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cyc_q   <= cyc_d;
      eval_q  <= eval_d;
      ones_q  <= ones_d;
      puf_q   <= puf_d;
      sync1_q <= r_mux;
      sync2_q <= sync1_q;
      busy_q  <= busy_d;
      resp_q  <= resp_d;
      unst_q  <= unst_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  // One register feeds both inputs so a and b release on the same edge.
  assign puf_a_o      = puf_q;
  assign puf_b_o      = puf_q;
  assign busy_o       = busy_q;
  assign resp_o       = resp_q;
  assign unstable_o   = unst_q;
  assign ones_cnt_o   = ones_q;
  assign err_o        = err_q;
  assign resp_valid_o = valid_q;

endmodule

// File: tb/tb_sr_puf_eval_ctrl.sv
// Bench for sr_puf_eval_ctrl: latch model, scoreboard, directed steps.
// Second instance with six cells covers the out-of-range challenge.
module tb_sr_puf_eval_ctrl;

  localparam int NE  = 7;
  localparam int EX  = 4;
  localparam int ST  = 16;
  localparam int LAT = NE * (EX + ST + 1);

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start;
  logic [2:0] challenge;
  logic       busy;
  logic [7:0] puf_a, puf_b;
  logic [7:0] puf_r = 8'h00;
  logic       resp, unstable;
  logic [7:0] ones_cnt;
  logic       err, resp_valid, resp_ready;

  logic       start6;
  logic [2:0] ch6;
  logic       busy6;
  logic [5:0] pa6, pb6;
  logic [5:0] pr6 = 6'h00;
  logic       resp6, unst6;
  logic [7:0] ones6;
  logic       err6, rv6, rr6;

  sr_puf_eval_ctrl dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .start_i      (start),
    .challenge_i  (challenge),
    .busy_o       (busy),
    .puf_a_o      (puf_a),
    .puf_b_o      (puf_b),
    .puf_r_i      (puf_r),
    .resp_o       (resp),
    .unstable_o   (unstable),
    .ones_cnt_o   (ones_cnt),
    .err_o        (err),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready)
  );

  sr_puf_eval_ctrl #(.NUM_CELLS(6)) dut6 (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .start_i      (start6),
    .challenge_i  (ch6),
    .busy_o       (busy6),
    .puf_a_o      (pa6),
    .puf_b_o      (pb6),
    .puf_r_i      (pr6),
    .resp_o       (resp6),
    .unstable_o   (unst6),
    .ones_cnt_o   (ones6),
    .err_o        (err6),
    .resp_valid_o (rv6),
    .resp_ready_i (rr6)
  );

  typedef struct {
    bit         resp;
    bit         unst;
    logic [7:0] ones;
    int         lat;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t cur;
  bit   res_q[$];
  int   exp_sel  = 0;
  bit   mon_en   = 1'b0;
  int   low_run  = 0;
  logic [7:0] prev_a = 8'hFF;
  logic [7:0] hole;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Latch model: excitation drives r high, release resolves it to the
  // next value queued by the stimulus.
  always @(negedge clk) begin
    if (mon_en) begin
      hole = ~(8'h01 << exp_sel);
      chk("a_eq_b", puf_a, puf_b);
      chk("puf_shape", (puf_a === 8'hFF) || (puf_a === hole), 1);
      chk("err_dut_a_idle", pa6, 6'h3F);
      chk("err_dut_b_idle", pb6, 6'h3F);
      if (puf_a != 8'hFF) begin
        low_run <= low_run + 1;
      end else if (low_run != 0) begin
        chk("excite_len", low_run, EX);
        low_run <= 0;
      end
      for (int i = 0; i < 8; i++) begin
        if (prev_a[i] && !puf_a[i])
          puf_r[i] <= 1'b1;
        else if (!prev_a[i] && puf_a[i])
          puf_r[i] <= (res_q.size() > 0) ? res_q.pop_front() : 1'b0;
      end
      prev_a <= puf_a;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_puf_a"}, puf_a, 8'hFF);
    chk({tag, "_puf_b"}, puf_b, 8'hFF);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, resp_valid, 0);
    chk({tag, "_resp"}, resp, 0);
    chk({tag, "_unst"}, unstable, 0);
    chk({tag, "_ones"}, ones_cnt, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // seq[0] is the first evaluation's resolved value.
  task automatic start_eval(input logic [2:0] ch, input logic [6:0] seq);
    exp_t e;
    int   n1;
    n1 = 0;
    for (int i = 0; i < NE; i++) begin
      res_q.push_back(seq[i]);
      n1 += int'(seq[i]);
    end
    e.ones = 8'(n1);
    e.resp = (n1 > NE / 2);
    e.unst = (n1 != 0) && (n1 != NE);
    e.lat  = LAT;
    sb.push_back(e);
    @(negedge clk);
    start     = 1'b1;
    challenge = ch;
    exp_sel   = int'(ch);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (resp_valid !== 1'b1 && n < LAT + 50) begin
      tick();
      n++;
    end
    chk("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      chk("latency", n, cur.lat);
      chk("resp_valid", resp_valid, 1);
      chk("resp", resp, cur.resp);
      chk("unstable", unstable, cur.unst);
      chk("ones_cnt", ones_cnt, cur.ones);
      chk("err", err, 0);
      chk("busy_done", busy, 1);
    end
  endtask

  task automatic consume(input bit with_start);
    @(negedge clk);
    resp_ready = 1'b1;
    if (with_start) begin
      start     = 1'b1;
      challenge = 3'd1;
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    start      = 1'b0;
    chk("valid_fall", resp_valid, 0);
    chk("busy_fall", busy, 0);
    chk("ones_kept", ones_cnt, cur.ones);
    chk("resp_kept", resp, cur.resp);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    challenge  = 3'd0;
    resp_ready = 1'b0;
    start6     = 1'b0;
    ch6        = 3'd0;
    rr6        = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    chk("reset_err_dut_valid", rv6, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    start_eval(3'd5, 7'b1111111);
    wait_resp();
    consume(1'b0);

    start_eval(3'd2, 7'b1001101);
    wait_resp();
    consume(1'b0);

    start_eval(3'd6, 7'b0101010);
    wait_resp();
    consume(1'b0);

    start_eval(3'd0, 7'b0000000);
    wait_resp();
    for (int i = 0; i < 20; i++) begin
      start     = (i == 10);
      challenge = 3'd1;
      tick();
      chk("bp_valid", resp_valid, 1);
      chk("bp_busy", busy, 1);
      chk("bp_ones", ones_cnt, cur.ones);
      chk("bp_resp", resp, cur.resp);
      chk("bp_unst", unstable, cur.unst);
      chk("bp_puf", puf_a, 8'hFF);
    end
    start = 1'b0;
    consume(1'b1);
    tick();
    chk("start_at_handshake_ignored", busy, 0);

    start_eval(3'd1, 7'b1110111);
    wait_resp();
    consume(1'b0);

    @(negedge clk);
    start6 = 1'b1;
    ch6    = 3'd7;
    @(posedge clk);
    #1;
    start6 = 1'b0;
    chk("err_valid", rv6, 1);
    chk("err_flag", err6, 1);
    chk("err_resp", resp6, 0);
    chk("err_unst", unst6, 0);
    chk("err_ones", ones6, 0);
    chk("err_busy", busy6, 1);
    repeat (3) tick();
    chk("err_hold", rv6, 1);
    @(negedge clk);
    rr6 = 1'b1;
    @(posedge clk);
    #1;
    rr6 = 1'b0;
    chk("err_valid_fall", rv6, 0);
    chk("err_busy_fall", busy6, 0);
    chk("err_flag_kept", err6, 1);

    start_eval(3'd3, 7'b1111111);
    repeat (50) tick();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_vals("midrst");
    void'(sb.pop_back());
    res_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();
    chk("midrst_no_resp", resp_valid, 0);
    chk("midrst_idle", busy, 0);

    start_eval(3'd3, 7'b1110100);
    wait_resp();
    consume(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
